// File: rtl/fft_r22sdf_bf_pkg.sv
// Shared constants for one radix-2^2 single-delay-feedback butterfly stage.
// Holds the derivation of the two feedback depths, the control bit positions
// and the stage latency from the FFT length and the stage index.
package fft_r22sdf_bf_pkg;

    // BF I feedback depth: half of the sub-frame this stage works on.
    function automatic int unsigned dl1_depth(input int unsigned fft_n, input int unsigned stage);
        return fft_n >> (2 * stage + 1);
    endfunction

    // BF II feedback depth: half of BF I's depth.
    function automatic int unsigned dl2_depth(input int unsigned fft_n, input int unsigned stage);
        return dl1_depth(fft_n, stage) >> 1;
    endfunction

    // Counter bit that selects the BF I butterfly half.
    function automatic int unsigned hi_bit(input int unsigned nlog2, input int unsigned stage);
        return nlog2 - 1 - 2 * stage;
    endfunction

    // Counter bit that selects the BF II butterfly half.
    function automatic int unsigned lo_bit(input int unsigned nlog2, input int unsigned stage);
        return nlog2 - 2 - 2 * stage;
    endfunction

    // Cycles from a sample entering to the matching result index leaving.
    function automatic int unsigned stage_latency(input int unsigned fft_n,
                                                  input int unsigned stage);
        return dl1_depth(fft_n, stage) + dl2_depth(fft_n, stage) + 2;
    endfunction

endpackage

// File: rtl/fft_r22sdf_bf_if.sv
// Sample stream interface of one butterfly stage.
//   ctr_i        sample index travelling with x, increments once per clock
//   x_re_i/x_im_i signed input sample
//   ctr_o        result index aligned with z
//   z_re_o/z_im_o signed result, two bits wider than x
// master: the side producing x and consuming z; slave: the butterfly stage.
interface fft_r22sdf_bf_if #(
    parameter int unsigned DATA_WIDTH = 25,
    parameter int unsigned NLOG2      = 10
);
    logic        [NLOG2-1:0]      ctr_i;
    logic signed [DATA_WIDTH-1:0] x_re_i;
    logic signed [DATA_WIDTH-1:0] x_im_i;
    logic        [NLOG2-1:0]      ctr_o;
    logic signed [DATA_WIDTH+1:0] z_re_o;
    logic signed [DATA_WIDTH+1:0] z_im_o;

    modport master (
        output ctr_i, x_re_i, x_im_i,
        input  ctr_o, z_re_o, z_im_o
    );

    modport slave (
        input  ctr_i, x_re_i, x_im_i,
        output ctr_o, z_re_o, z_im_o
    );
endinterface

// File: rtl/fft_r22sdf_bf_delay.sv
// Feedback delay line for a single-delay-feedback butterfly.
// RAM-style circular buffer: every clock the slot under the pointer is read
// (old contents) and overwritten, so a read returns the word written DEPTH
// clocks earlier. Until DEPTH writes have happened since reset the read
// returns zero, so data from before a reset never reappears.
//   clk_i      clock
//   rst_n      asynchronous active-low reset (pointer and fill count only)
//   wr_data_i  word written this clock
//   rd_data_o  word written DEPTH clocks ago, or zero while filling
module fft_sdf_delay #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0]  fill_q, fill_d;
    logic             full;

    always_comb begin
        full      = (fill_q == CntW'(DEPTH));
        ptr_d     = (ptr_q == PtrW'(DEPTH - 1)) ? '0 : ptr_q + PtrW'(1);
        fill_d    = full ? fill_q : fill_q + CntW'(1);
        rd_data_o = full ? mem_q[ptr_q] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            fill_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            fill_q <= fill_d;
        end
    end

    // Storage is deliberately not reset; the fill count masks stale words.
    always_ff @(posedge clk_i) begin
        mem_q[ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/fft_r22sdf_bf.sv
// One radix-2^2 SDF butterfly stage (BF I, trivial -j twiddle, BF II).
// Streams one complex sample per clock, no handshake. Each butterfly adds one
// bit of growth; full precision, no rounding or saturation.
//   clk_i  clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of the stage stream (ctr_i, x in; ctr_o, z out)
module fft_r22sdf_bf
    import fft_r22sdf_bf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 25,
    parameter int unsigned FFT_N      = 1024,
    parameter int unsigned NLOG2      = 10,
    parameter int unsigned STAGE      = 0
) (
    input logic          clk_i,
    input logic          rst_n,
    fft_r22sdf_bf_if.slave bus
);
    localparam int unsigned Dl1  = dl1_depth(FFT_N, STAGE);
    localparam int unsigned Dl2  = dl2_depth(FFT_N, STAGE);
    localparam int unsigned HBit = hi_bit(NLOG2, STAGE);
    localparam int unsigned LBit = lo_bit(NLOG2, STAGE);
    localparam int unsigned Lat  = stage_latency(FFT_N, STAGE);
    localparam int unsigned W1   = DATA_WIDTH + 1;
    localparam int unsigned W2   = DATA_WIDTH + 2;

    typedef struct packed {
        logic signed [W1-1:0] re;
        logic signed [W1-1:0] im;
    } cplx1_t;

    typedef struct packed {
        logic signed [W2-1:0] re;
        logic signed [W2-1:0] im;
    } cplx2_t;

    cplx1_t           x_ext, bf1_rd, bf1_wr, bf1_out, bf1_q;
    cplx2_t           bf2_ext, bf2_in, bf2_rd, bf2_wr, bf2_out, z_q;
    logic [1:0]       ctr1_q;  // {H, L} bits of the index delayed with bf1_q
    logic [NLOG2-1:0] ctr_o_q;

    // BF I
    always_comb begin
        x_ext.re = {bus.x_re_i[DATA_WIDTH-1], bus.x_re_i};
        x_ext.im = {bus.x_im_i[DATA_WIDTH-1], bus.x_im_i};
        if (bus.ctr_i[HBit]) begin
            bf1_out.re = bf1_rd.re + x_ext.re;
            bf1_out.im = bf1_rd.im + x_ext.im;
            bf1_wr.re  = bf1_rd.re - x_ext.re;
            bf1_wr.im  = bf1_rd.im - x_ext.im;
        end else begin
            bf1_out = bf1_rd;
            bf1_wr  = x_ext;
        end
    end

    fft_sdf_delay #(
        .WIDTH (2 * W1),
        .DEPTH (Dl1)
    ) u_dl1 (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .wr_data_i (bf1_wr),
        .rd_data_o (bf1_rd)
    );

    // Twiddle and BF II
    always_comb begin
        bf2_ext.re = {bf1_q.re[W1-1], bf1_q.re};
        bf2_ext.im = {bf1_q.im[W1-1], bf1_q.im};
        // -j in the second quarter; widened first so negating -2^(W1-1) fits.
        if (!ctr1_q[1] && ctr1_q[0]) begin
            bf2_in.re = bf2_ext.im;
            bf2_in.im = -bf2_ext.re;
        end else begin
            bf2_in = bf2_ext;
        end
        if (ctr1_q[0]) begin
            bf2_out.re = bf2_rd.re + bf2_in.re;
            bf2_out.im = bf2_rd.im + bf2_in.im;
            bf2_wr.re  = bf2_rd.re - bf2_in.re;
            bf2_wr.im  = bf2_rd.im - bf2_in.im;
        end else begin
            bf2_out = bf2_rd;
            bf2_wr  = bf2_in;
        end
    end

    fft_sdf_delay #(
        .WIDTH (2 * W2),
        .DEPTH (Dl2)
    ) u_dl2 (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .wr_data_i (bf2_wr),
        .rd_data_o (bf2_rd)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            bf1_q   <= '0;
            ctr1_q  <= '0;
            z_q     <= '0;
            ctr_o_q <= '0;
        end else begin
            bf1_q   <= bf1_out;
            ctr1_q  <= {bus.ctr_i[HBit], bus.ctr_i[LBit]};
            z_q     <= bf2_out;
            // Registered, so one less than Lat keeps it equal to ctr_i - Lat.
            ctr_o_q <= bus.ctr_i - NLOG2'(Lat - 1);
        end
    end

    assign bus.ctr_o  = ctr_o_q;
    assign bus.z_re_o = z_q.re;
    assign bus.z_im_o = z_q.im;
endmodule

// File: tb/tb_fft_r22sdf_bf.sv
// Self-checking bench for fft_r22sdf_bf (FFT_N=16, STAGE=0, DATA_WIDTH=8).
// Expected z comes from the quarter equations applied to the recorded input
// frame; samples taken while reset was active, or before the latest reset,
// count as zero.
module tb_fft_r22sdf_bf;
    localparam int unsigned DW    = 8;
    localparam int unsigned FN    = 16;
    localparam int unsigned NL    = 4;
    localparam int unsigned STG   = 0;
    localparam int          N     = 16;
    localparam int          DL2   = 4;
    localparam int          LAT   = 14;
    localparam int          NEDGE = 15 * N;

    logic clk_i = 1'b0;
    logic rst_n;

    always #5 clk_i = ~clk_i;

    fft_r22sdf_bf_if #(.DATA_WIDTH(DW), .NLOG2(NL)) bus ();

    fft_r22sdf_bf #(
        .DATA_WIDTH (DW),
        .FFT_N      (FN),
        .NLOG2      (NL),
        .STAGE      (STG)
    ) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int xr_hist [NEDGE];
    int xi_hist [NEDGE];
    int last_rst;
    int edge_n;
    int n_checks;
    int n_pass;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
    endtask

    function automatic int samp(input int e, input bit im);
        if (e < 0 || e <= last_rst) return 0;
        return im ? xi_hist[e] : xr_hist[e];
    endfunction

    // Result index k of the frame whose first sample was latched at edge s.
    task automatic model(input int n, input int k, output int er, output int ei);
        int s, m, p, ar, ai, br, bi, cr, ci, dr, di;
        int xr [4];
        int xi [4];
        s = n - (LAT - 1) - k;
        m = k % DL2;
        p = k / DL2;
        for (int q = 0; q < 4; q++) begin
            xr[q] = samp(s + q * DL2 + m, 1'b0);
            xi[q] = samp(s + q * DL2 + m, 1'b1);
        end
        ar = xr[0] + xr[2]; ai = xi[0] + xi[2];
        br = xr[1] + xr[3]; bi = xi[1] + xi[3];
        cr = xr[0] - xr[2]; ci = xi[0] - xi[2];
        dr = xr[1] - xr[3]; di = xi[1] - xi[3];
        case (p)
            0:       begin er = ar + br; ei = ai + bi; end
            1:       begin er = ar - br; ei = ai - bi; end
            2:       begin er = cr + di; ei = ci - dr; end  // C - jD
            default: begin er = cr - di; ei = ci + dr; end  // C + jD
        endcase
    endtask

    initial begin
        int   c, f, xr, xi, k, er, ei;
        logic rst_v;
        n_checks = 0;
        n_pass   = 0;
        last_rst = -1;
        edge_n   = 0;
        rst_n    = 1'b0;
        bus.ctr_i  = '0;
        bus.x_re_i = '0;
        bus.x_im_i = '0;
        for (int n = 0; n < NEDGE; n++) begin
            c     = n % N;
            f     = n / N - 1;
            xr    = 0;
            xi    = 0;
            rst_v = 1'b1;
            case (f)
                -1: rst_v = 1'b0;
                0:  xr = (c == 0) ? 1 : 0;
                1:  xr = (c == 4) ? 1 : 0;
                2:  xr = 1;
                3:  begin xr = -128; xi = -128; end
                5, 6, 7, 8, 11: begin
                    xr = int'($urandom_range(255)) - 128;
                    xi = int'($urandom_range(255)) - 128;
                end
                10: begin
                    xr    = (c < 6) ? 1 : 0;
                    rst_v = (c >= 6 && c <= 8) ? 1'b0 : 1'b1;
                end
                default: ;
            endcase

            if (!rst_v && rst_n) begin
                rst_n = 1'b0;
                #1;
                check("async_rst_z_re", int'(bus.z_re_o), 0);
                check("async_rst_z_im", int'(bus.z_im_o), 0);
                check("async_rst_ctr_o", int'(bus.ctr_o), 0);
            end else begin
                rst_n = rst_v;
            end

            bus.ctr_i  = NL'(c);
            bus.x_re_i = DW'(xr);
            bus.x_im_i = DW'(xi);
            xr_hist[n] = xr;
            xi_hist[n] = xi;

            @(posedge clk_i);
            edge_n = n;
            if (!rst_n) last_rst = n;
            #1;
            if (!rst_n) begin
                check("rst_z_re", int'(bus.z_re_o), 0);
                check("rst_z_im", int'(bus.z_im_o), 0);
                check("rst_ctr_o", int'(bus.ctr_o), 0);
            end else begin
                k = (c + 1 - LAT + 2 * N) % N;
                model(n, k, er, ei);
                check("ctr_o", int'(bus.ctr_o), k);
                check("z_re", int'(bus.z_re_o), er);
                check("z_im", int'(bus.z_im_o), ei);
            end
            @(negedge clk_i);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
